canvas_buffer: RTL and testbench
================================

Name: canvas_buffer

Overview:
- Single-port-write, dual-port-read frame store for the 96x64 drawing canvas; the receiving end of the drawing block's pixel writes.
- Captures each qualified pixel write (colour at x,y) into a 6144x16 RGB565 memory.
- Serves two synchronous read ports: the OLED scan (pixel_index) and the cursor pixel colour fed back to the drawing logic.
- Owns canvas initialisation and clear via an internal sweep FSM.

Parameters:
- WIDTH, 96, canvas width in pixels.
- HEIGHT, 64, canvas height in pixels.
- CLEAR_COLOUR, 16'hFFFF, colour written by every clear sweep.

Ports:
- CLOCK  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe; one pixel per cycle while high.
- wr_x  in  8  write column.
- wr_y  in  8  write row.
- wr_colour  in  16  RGB565 colour to store.
- pixel_index  in  13  OLED scan address, y*WIDTH+x.
- oled_data  out  16  stored colour at pixel_index.
- curr_pixel_x  in  8  cursor column.
- curr_pixel_y  in  8  cursor row.
- curr_pixel_colour  out  16  stored colour at the cursor.
- clear_req  in  1  level or pulse; requests a full clear.
- busy  out  1  high while a clear sweep runs.
- clear_done  out  1  one-cycle pulse when a sweep completes.
- dirty  out  1  canvas written since the last completed clear.

Behaviour:
- Reset (async): state=CLEAR, sweep address=0, busy=1, clear_done=0, dirty=0, oled_data=0, curr_pixel_colour=0.
- Memory contents are not reset. The sweep run on reset release initialises them.
- Write address = wr_y*WIDTH+wr_x, computed at 13 bits.
- A write commits only if wr_en=1, state=IDLE, wr_x<WIDTH and wr_y<HEIGHT. Otherwise it is dropped silently with no wrap-around.
- A committed write sets dirty=1 on the same clock edge.
- Display read: oled_data is registered with 1-cycle latency.
  - pixel_index>=WIDTH*HEIGHT (6144..8191) gives oled_data=0 on the next cycle.
- Cursor read: curr_pixel_colour is registered with 1-cycle latency from curr_pixel_x/curr_pixel_y.
  - Cursor coordinates out of range give 0.
- Read-during-write to the same address on either port: read-first. The port returns the old data that cycle and the new data from the following cycle.
- Both read ports operate in every state, including CLEAR. Mid-sweep reads return a mix of old data and CLEAR_COLOUR.
- FSM states: IDLE, CLEAR.
  - IDLE -> CLEAR when clear_req=1 is sampled. Sweep address is loaded with 0 and busy rises the next cycle.
  - CLEAR writes CLEAR_COLOUR at the sweep address each cycle and increments the address.
  - When the write at address 6143 occurs: go to IDLE, busy=0, clear_done=1 for exactly one cycle, dirty=0. Total sweep is 6144 cycles.
  - clear_req while in CLEAR is ignored; it is not queued.
  - If clear_req is still high on the first IDLE cycle, a new sweep starts.
  - wr_en in CLEAR is dropped, not buffered.
- Simultaneous events in IDLE: clear_req has priority over wr_en in the same cycle. The write is dropped and the sweep starts.
- Reset asserted mid-sweep aborts it and restarts from address 0 after release.
- Sweep counter is 13 bits. Terminal compare is at WIDTH*HEIGHT-1.

Test Plan:
- Reset release, hold inputs idle -> busy=1 for exactly 6144 cycles, one clear_done pulse, then oled_data=16'hFFFF at indices 0, 3000 and 6143; dirty=0.
- After the sweep, write x=5,y=2,colour=16'h07E0, then set pixel_index=197 -> oled_data=16'h07E0 one cycle later. Set cursor (5,2) -> curr_pixel_colour=16'h07E0. dirty=1.
- Write x=96,y=0 and x=0,y=64 with colour 16'h0000 -> indices 0 and 6143 still read 16'hFFFF. dirty unchanged.
- Same-cycle write (10,10)=16'hF800 while cursor=(10,10) -> curr_pixel_colour=16'hFFFF that cycle and 16'hF800 the next.
- Assert clear_req and wr_en together in IDLE -> write dropped, busy rises. wr_en during the sweep is dropped. A second clear_req mid-sweep does not extend the 6144-cycle sweep. Completion gives dirty=0.
- Assert reset at sweep address ~3000 -> outputs return to reset values immediately; after release a full 6144-cycle sweep runs again.

Source files
------------

// File: rtl/canvas_buffer_if.sv
// Pixel-write, display-read, cursor-read and clear-control signals of the canvas frame store.
interface canvas_buffer_if;
    logic        wr_en;
    logic [7:0]  wr_x;
    logic [7:0]  wr_y;
    logic [15:0] wr_colour;
    logic [12:0] pixel_index;
    logic [15:0] oled_data;
    logic [7:0]  curr_pixel_x;
    logic [7:0]  curr_pixel_y;
    logic [15:0] curr_pixel_colour;
    logic        clear_req;
    logic        busy;
    logic        clear_done;
    logic        dirty;

    modport master (
        output wr_en, wr_x, wr_y, wr_colour, pixel_index,
               curr_pixel_x, curr_pixel_y, clear_req,
        input  oled_data, curr_pixel_colour, busy, clear_done, dirty
    );

    modport slave (
        input  wr_en, wr_x, wr_y, wr_colour, pixel_index,
               curr_pixel_x, curr_pixel_y, clear_req,
        output oled_data, curr_pixel_colour, busy, clear_done, dirty
    );
endinterface

// File: rtl/canvas_buffer.sv
// 96x64 RGB565 canvas store: one write port shared by pixel writes and the clear sweep,
// two registered read-first read ports (OLED scan and drawing cursor).
module canvas_buffer #(
    parameter int          WIDTH        = 96,
    parameter int          HEIGHT       = 64,
    parameter logic [15:0] CLEAR_COLOUR = 16'hFFFF
) (
    input logic             CLOCK,
    input logic             reset,
    canvas_buffer_if.slave  bus
);

    localparam int          DEPTH     = WIDTH * HEIGHT;
    localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [0:0]  state_q, state_d;
    logic [12:0] sweep_addr_q, sweep_addr_d;
    logic        clear_done_q, clear_done_d;
    logic        dirty_q, dirty_d;
    logic [15:0] oled_q, cursor_q;

    logic [15:0] mem [DEPTH];

    logic        mem_we;
    logic [12:0] mem_addr;
    logic [15:0] mem_wdata;

    logic [12:0] wr_addr, cur_addr;
    logic        wr_in_range, cur_in_range, pix_in_range;

    assign wr_addr      = 13'(bus.wr_y) * 13'(WIDTH) + 13'(bus.wr_x);
    assign cur_addr     = 13'(bus.curr_pixel_y) * 13'(WIDTH) + 13'(bus.curr_pixel_x);
    assign wr_in_range  = (bus.wr_x < 8'(WIDTH)) && (bus.wr_y < 8'(HEIGHT));
    assign cur_in_range = (bus.curr_pixel_x < 8'(WIDTH)) && (bus.curr_pixel_y < 8'(HEIGHT));
    assign pix_in_range = bus.pixel_index < 13'(DEPTH);

    // NOTE: every signal gets a default before the branches, so no latch can be inferred.
    always_comb begin
        state_d      = state_q;
        sweep_addr_d = sweep_addr_q;
        clear_done_d = 1'b0;
        dirty_d      = dirty_q;
        mem_we       = 1'b0;
        mem_addr     = wr_addr;
        mem_wdata    = bus.wr_colour;

        if (state_q == ST_IDLE) begin
            // A clear request wins over a same-cycle pixel write, which is dropped.
            if (bus.clear_req) begin
                state_d      = ST_CLEAR;
                sweep_addr_d = '0;
            end else if (bus.wr_en && wr_in_range) begin
                mem_we  = 1'b1;
                dirty_d = 1'b1;
            end
        end else begin
            mem_we    = 1'b1;
            mem_addr  = sweep_addr_q;
            mem_wdata = CLEAR_COLOUR;
            if (sweep_addr_q == LAST_ADDR) begin
                state_d      = ST_IDLE;
                sweep_addr_d = '0;
                clear_done_d = 1'b1;
                dirty_d      = 1'b0;
            end else begin
                sweep_addr_d = sweep_addr_q + 13'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            state_q      <= ST_CLEAR;
            sweep_addr_q <= '0;
            clear_done_q <= 1'b0;
            dirty_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            sweep_addr_q <= sweep_addr_d;
            clear_done_q <= clear_done_d;
            dirty_q      <= dirty_d;
        end
    end

    // NOTE: the array has no reset; the sweep after reset release initialises it.
    always_ff @(posedge CLOCK) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Reads sample the array before this edge's write lands, giving read-first behaviour.
    always_ff @(posedge CLOCK or posedge reset) begin
        if (reset) begin
            oled_q   <= '0;
            cursor_q <= '0;
        end else begin
            oled_q   <= pix_in_range ? mem[bus.pixel_index] : 16'h0000;
            cursor_q <= cur_in_range ? mem[cur_addr] : 16'h0000;
        end
    end

    assign bus.oled_data         = oled_q;
    assign bus.curr_pixel_colour = cursor_q;
    assign bus.busy              = (state_q == ST_CLEAR);
    assign bus.clear_done        = clear_done_q;
    assign bus.dirty             = dirty_q;

endmodule

// File: tb/tb_canvas_buffer.sv
// Directed bench for canvas_buffer: sweep timing, pixel writes, bounds, read-first, clear priority, reset abort.
module tb_canvas_buffer;

    logic CLOCK;
    logic reset;
    int   n_cmp;
    int   n_err;

    canvas_buffer_if cb_if ();

    canvas_buffer #(
        .WIDTH       (96),
        .HEIGHT      (64),
        .CLEAR_COLOUR(16'hFFFF)
    ) dut (
        .CLOCK (CLOCK),
        .reset (reset),
        .bus   (cb_if)
    );

    initial begin
        CLOCK = 1'b0;
        forever #5 CLOCK = ~CLOCK;
    end

    // Counts negedge samples with busy high, up to a bound, and any clear_done seen while busy.
    task automatic wait_sweep(output int cycles, output int early_done);
        cycles     = 0;
        early_done = 0;
        while (cb_if.busy === 1'b1 && cycles < 10000) begin
            cycles++;
            if (cb_if.clear_done !== 1'b0) early_done++;
            @(negedge CLOCK);
        end
    endtask

    task automatic do_write(input logic [7:0] x, input logic [7:0] y, input logic [15:0] c);
        cb_if.wr_x      = x;
        cb_if.wr_y      = y;
        cb_if.wr_colour = c;
        cb_if.wr_en     = 1'b1;
        @(negedge CLOCK);
        cb_if.wr_en     = 1'b0;
    endtask

    task automatic read_pixel(input logic [12:0] idx, output logic [15:0] val);
        cb_if.pixel_index = idx;
        @(negedge CLOCK);
        val = cb_if.oled_data;
    endtask

    task automatic read_cursor(input logic [7:0] x, input logic [7:0] y, output logic [15:0] val);
        cb_if.curr_pixel_x = x;
        cb_if.curr_pixel_y = y;
        @(negedge CLOCK);
        val = cb_if.curr_pixel_colour;
    endtask

    task automatic test_reset();
        int          cycles, early;
        logic [15:0] v;
        #12;
        n_cmp++; if (cb_if.busy !== 1'b1) begin n_err++; $display("FAIL reset_busy: got %b want 1", cb_if.busy); end
        n_cmp++; if (cb_if.clear_done !== 1'b0) begin n_err++; $display("FAIL reset_clear_done: got %b want 0", cb_if.clear_done); end
        n_cmp++; if (cb_if.dirty !== 1'b0) begin n_err++; $display("FAIL reset_dirty: got %b want 0", cb_if.dirty); end
        n_cmp++; if (cb_if.oled_data !== 16'h0000) begin n_err++; $display("FAIL reset_oled: got %h want 0000", cb_if.oled_data); end
        n_cmp++; if (cb_if.curr_pixel_colour !== 16'h0000) begin n_err++; $display("FAIL reset_cursor: got %h want 0000", cb_if.curr_pixel_colour); end
        @(negedge CLOCK);
        reset = 1'b0;
        wait_sweep(cycles, early);
        n_cmp++; if (cycles !== 6144) begin n_err++; $display("FAIL init_sweep_len: got %0d want 6144", cycles); end
        n_cmp++; if (early !== 0) begin n_err++; $display("FAIL init_early_done: got %0d want 0", early); end
        n_cmp++; if (cb_if.clear_done !== 1'b1) begin n_err++; $display("FAIL init_done_pulse: got %b want 1", cb_if.clear_done); end
        @(negedge CLOCK);
        n_cmp++; if (cb_if.clear_done !== 1'b0) begin n_err++; $display("FAIL init_done_width: got %b want 0", cb_if.clear_done); end
        read_pixel(13'd0, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL init_pix0: got %h want ffff", v); end
        read_pixel(13'd3000, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL init_pix3000: got %h want ffff", v); end
        read_pixel(13'd6143, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL init_pix6143: got %h want ffff", v); end
        read_pixel(13'd6144, v);
        n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL pix_oob6144: got %h want 0000", v); end
        n_cmp++; if (cb_if.dirty !== 1'b0) begin n_err++; $display("FAIL init_dirty: got %b want 0", cb_if.dirty); end
    endtask

    task automatic test_write_read();
        logic [15:0] v;
        do_write(8'd5, 8'd2, 16'h07E0);
        read_pixel(13'd197, v);
        n_cmp++; if (v !== 16'h07E0) begin n_err++; $display("FAIL wr_pix197: got %h want 07e0", v); end
        read_cursor(8'd5, 8'd2, v);
        n_cmp++; if (v !== 16'h07E0) begin n_err++; $display("FAIL wr_cursor52: got %h want 07e0", v); end
        n_cmp++; if (cb_if.dirty !== 1'b1) begin n_err++; $display("FAIL wr_dirty: got %b want 1", cb_if.dirty); end
    endtask

    task automatic test_out_of_range();
        logic [15:0] v;
        do_write(8'd96, 8'd0, 16'h0000);
        do_write(8'd0, 8'd64, 16'h0000);
        read_pixel(13'd0, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL oob_pix0: got %h want ffff", v); end
        read_pixel(13'd96, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL oob_pix96: got %h want ffff", v); end
        read_pixel(13'd6143, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL oob_pix6143: got %h want ffff", v); end
        read_cursor(8'd96, 8'd0, v);
        n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL oob_cursor_x: got %h want 0000", v); end
        read_cursor(8'd0, 8'd64, v);
        n_cmp++; if (v !== 16'h0000) begin n_err++; $display("FAIL oob_cursor_y: got %h want 0000", v); end
        n_cmp++; if (cb_if.dirty !== 1'b1) begin n_err++; $display("FAIL oob_dirty: got %b want 1", cb_if.dirty); end
    endtask

    task automatic test_read_during_write();
        logic [15:0] v;
        read_cursor(8'd10, 8'd10, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL rdw_before: got %h want ffff", v); end
        do_write(8'd10, 8'd10, 16'hF800);
        n_cmp++; if (cb_if.curr_pixel_colour !== 16'hFFFF) begin n_err++; $display("FAIL rdw_same_cycle: got %h want ffff", cb_if.curr_pixel_colour); end
        @(negedge CLOCK);
        n_cmp++; if (cb_if.curr_pixel_colour !== 16'hF800) begin n_err++; $display("FAIL rdw_next_cycle: got %h want f800", cb_if.curr_pixel_colour); end
    endtask

    task automatic test_clear_priority();
        int          cnt;
        logic [15:0] v;
        cb_if.clear_req = 1'b1;
        cb_if.wr_x      = 8'd20;
        cb_if.wr_y      = 8'd20;
        cb_if.wr_colour = 16'h001F;
        cb_if.wr_en     = 1'b1;
        @(negedge CLOCK);
        n_cmp++; if (cb_if.busy !== 1'b1) begin n_err++; $display("FAIL clr_busy_rise: got %b want 1", cb_if.busy); end
        cnt = 0;
        while (cb_if.busy === 1'b1 && cnt < 10000) begin
            cnt++;
            if (cnt == 1) begin
                cb_if.clear_req   = 1'b0;
                cb_if.wr_en       = 1'b0;
                cb_if.pixel_index = 13'd970;
            end
            if (cnt == 2) begin
                n_cmp++; if (cb_if.oled_data !== 16'hF800) begin n_err++; $display("FAIL clr_mid_old: got %h want f800", cb_if.oled_data); end
                n_cmp++; if (cb_if.dirty !== 1'b1) begin n_err++; $display("FAIL clr_mid_dirty: got %b want 1", cb_if.dirty); end
            end
            if (cnt == 100) begin
                cb_if.wr_x      = 8'd0;
                cb_if.wr_y      = 8'd0;
                cb_if.wr_colour = 16'h1234;
                cb_if.wr_en     = 1'b1;
            end
            if (cnt == 101) cb_if.wr_en = 1'b0;
            if (cnt == 3000) cb_if.clear_req = 1'b1;
            if (cnt == 3001) cb_if.clear_req = 1'b0;
            @(negedge CLOCK);
        end
        n_cmp++; if (cnt !== 6144) begin n_err++; $display("FAIL clr_sweep_len: got %0d want 6144", cnt); end
        n_cmp++; if (cb_if.clear_done !== 1'b1) begin n_err++; $display("FAIL clr_done: got %b want 1", cb_if.clear_done); end
        n_cmp++; if (cb_if.dirty !== 1'b0) begin n_err++; $display("FAIL clr_dirty: got %b want 0", cb_if.dirty); end
        @(negedge CLOCK);
        n_cmp++; if (cb_if.busy !== 1'b0) begin n_err++; $display("FAIL clr_no_requeue: busy got %b want 0", cb_if.busy); end
        read_pixel(13'd0, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL clr_wr_dropped: got %h want ffff", v); end
        read_pixel(13'd970, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL clr_pix970: got %h want ffff", v); end
    endtask

    task automatic test_reset_mid_sweep();
        int          cnt, cycles, early;
        logic [15:0] v;
        do_write(8'd3, 8'd3, 16'hABCD);
        n_cmp++; if (cb_if.dirty !== 1'b1) begin n_err++; $display("FAIL rst_pre_dirty: got %b want 1", cb_if.dirty); end
        cb_if.pixel_index = 13'd0;
        cb_if.clear_req   = 1'b1;
        @(negedge CLOCK);
        cb_if.clear_req = 1'b0;
        cnt = 0;
        while (cb_if.busy === 1'b1 && cnt < 3000) begin
            cnt++;
            @(negedge CLOCK);
        end
        n_cmp++; if (cb_if.oled_data !== 16'hFFFF) begin n_err++; $display("FAIL rst_pre_oled: got %h want ffff", cb_if.oled_data); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (cb_if.busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_busy: got %b want 1", cb_if.busy); end
        n_cmp++; if (cb_if.dirty !== 1'b0) begin n_err++; $display("FAIL rst_mid_dirty: got %b want 0", cb_if.dirty); end
        n_cmp++; if (cb_if.oled_data !== 16'h0000) begin n_err++; $display("FAIL rst_mid_oled: got %h want 0000", cb_if.oled_data); end
        n_cmp++; if (cb_if.curr_pixel_colour !== 16'h0000) begin n_err++; $display("FAIL rst_mid_cursor: got %h want 0000", cb_if.curr_pixel_colour); end
        n_cmp++; if (cb_if.clear_done !== 1'b0) begin n_err++; $display("FAIL rst_mid_done: got %b want 0", cb_if.clear_done); end
        @(negedge CLOCK);
        reset = 1'b0;
        wait_sweep(cycles, early);
        n_cmp++; if (cycles !== 6144) begin n_err++; $display("FAIL rst_resweep_len: got %0d want 6144", cycles); end
        n_cmp++; if (cb_if.clear_done !== 1'b1) begin n_err++; $display("FAIL rst_resweep_done: got %b want 1", cb_if.clear_done); end
        read_pixel(13'd291, v);
        n_cmp++; if (v !== 16'hFFFF) begin n_err++; $display("FAIL rst_pix291: got %h want ffff", v); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset                = 1'b1;
        cb_if.wr_en          = 1'b0;
        cb_if.wr_x           = '0;
        cb_if.wr_y           = '0;
        cb_if.wr_colour      = '0;
        cb_if.pixel_index    = '0;
        cb_if.curr_pixel_x   = '0;
        cb_if.curr_pixel_y   = '0;
        cb_if.clear_req      = 1'b0;

        test_reset();
        test_write_read();
        test_out_of_range();
        test_read_during_write();
        test_clear_priority();
        test_reset_mid_sweep();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
